// File: rtl/grey_colourise.sv
// Grey-to-RGB expander for the display path: replicate, invert, threshold or palette
// pseudo-colour, with a double-buffered palette whose bank swap and mode change wait for vsync.
module grey_colourise #(
    parameter int DATA_WIDTH = 24,
    parameter int GREY_WIDTH = 8,
    parameter int THRESHOLD  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GREY_WIDTH-1:0] i_vid_data,
    input  logic                  i_vid_hsync,
    input  logic                  i_vid_vsync,
    input  logic                  i_vid_VDE,
    output logic [DATA_WIDTH-1:0] o_vid_data,
    output logic                  o_vid_hsync,
    output logic                  o_vid_vsync,
    output logic                  o_vid_VDE,
    input  logic [3:0]            btn,
    input  logic                  pal_wr_en,
    input  logic [GREY_WIDTH-1:0] pal_wr_addr,
    input  logic [DATA_WIDTH-1:0] pal_wr_data,
    input  logic                  pal_commit,
    output logic                  pal_pending
);

    localparam int DEPTH = 2 ** GREY_WIDTH;

    typedef enum logic [1:0] {
        MODE_GREY   = 2'b00,
        MODE_PAL    = 2'b01,
        MODE_INVERT = 2'b10,
        MODE_THRESH = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } commit_state_e;

    logic                  vsync_prev_q;
    logic                  frame_start;
    mode_e                 mode_q, mode_d;
    commit_state_e         state_q, state_d;
    logic                  bank_sel_q, bank_sel_d;

    logic [GREY_WIDTH-1:0] grey_s1_q;
    logic                  hsync_s1_q, vsync_s1_q, vde_s1_q;

    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic                  hsync_s2_q, vsync_s2_q, vde_s2_q;

    logic [DATA_WIDTH-1:0] pal0_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pal1_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pal_rd;

    logic                  unused_btn_hi;
    assign unused_btn_hi = &btn[3:2];

    assign frame_start = i_vid_vsync & ~vsync_prev_q;

    always_comb begin
        mode_d = mode_q;
        if (frame_start) begin
            mode_d = mode_e'(btn[1:0]);
        end
    end

    // A commit arriving on the frame-start cycle only moves IDLE->PENDING, so it swaps on the next one.
    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pal_commit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    state_d    = ST_IDLE;
                    bank_sel_d = ~bank_sel_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev_q <= 1'b0;
            mode_q       <= MODE_GREY;
            state_q      <= ST_IDLE;
            bank_sel_q   <= 1'b0;
        end else begin
            vsync_prev_q <= i_vid_vsync;
            mode_q       <= mode_d;
            state_q      <= state_d;
            bank_sel_q   <= bank_sel_d;
        end
    end

    assign pal_pending = (state_q == ST_PENDING);

    // Palette RAM is not reset; writes target the bank inactive before this edge.
    always_ff @(posedge clk) begin
        if (pal_wr_en) begin
            if (bank_sel_q) begin
                pal0_mem[pal_wr_addr] <= pal_wr_data;
            end else begin
                pal1_mem[pal_wr_addr] <= pal_wr_data;
            end
        end
    end

    assign pal_rd = bank_sel_q ? pal1_mem[grey_s1_q] : pal0_mem[grey_s1_q];

    always_comb begin
        pix_d = '0;
        if (vde_s1_q) begin
            unique case (mode_q)
                MODE_GREY:   pix_d = DATA_WIDTH'({3{grey_s1_q}});
                MODE_PAL:    pix_d = pal_rd;
                MODE_INVERT: pix_d = DATA_WIDTH'({3{~grey_s1_q}});
                MODE_THRESH: pix_d = (grey_s1_q >= GREY_WIDTH'(THRESHOLD)) ? '1 : '0;
                default:     pix_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grey_s1_q  <= '0;
            hsync_s1_q <= 1'b0;
            vsync_s1_q <= 1'b0;
            vde_s1_q   <= 1'b0;
            pix_q      <= '0;
            hsync_s2_q <= 1'b0;
            vsync_s2_q <= 1'b0;
            vde_s2_q   <= 1'b0;
        end else begin
            grey_s1_q  <= i_vid_data;
            hsync_s1_q <= i_vid_hsync;
            vsync_s1_q <= i_vid_vsync;
            vde_s1_q   <= i_vid_VDE;
            pix_q      <= pix_d;
            hsync_s2_q <= hsync_s1_q;
            vsync_s2_q <= vsync_s1_q;
            vde_s2_q   <= vde_s1_q;
        end
    end

    assign o_vid_data  = pix_q;
    assign o_vid_hsync = hsync_s2_q;
    assign o_vid_vsync = vsync_s2_q;
    assign o_vid_VDE   = vde_s2_q;

endmodule

// File: tb/tb_grey_colourise.sv
// Scoreboard bench for grey_colourise: the driver queues hand-computed expected outputs,
// a negedge monitor pops and compares them two pixel-cycles after issue.
module tb_grey_colourise;

    logic        clk;
    logic        rst;
    logic [7:0]  i_vid_data;
    logic        i_vid_hsync, i_vid_vsync, i_vid_VDE;
    logic [23:0] o_vid_data;
    logic        o_vid_hsync, o_vid_vsync, o_vid_VDE;
    logic [3:0]  btn;
    logic        pal_wr_en;
    logic [7:0]  pal_wr_addr;
    logic [23:0] pal_wr_data;
    logic        pal_commit;
    logic        pal_pending;

    grey_colourise #(
        .DATA_WIDTH(24),
        .GREY_WIDTH(8),
        .THRESHOLD (128)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_vid_data (i_vid_data),
        .i_vid_hsync(i_vid_hsync),
        .i_vid_vsync(i_vid_vsync),
        .i_vid_VDE  (i_vid_VDE),
        .o_vid_data (o_vid_data),
        .o_vid_hsync(o_vid_hsync),
        .o_vid_vsync(o_vid_vsync),
        .o_vid_VDE  (o_vid_VDE),
        .btn        (btn),
        .pal_wr_en  (pal_wr_en),
        .pal_wr_addr(pal_wr_addr),
        .pal_wr_data(pal_wr_data),
        .pal_commit (pal_commit),
        .pal_pending(pal_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] data;
        logic        hs;
        logic        vs;
        logic        de;
        logic [7:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec;
    int unsigned n_err;
    logic        mon_en;
    logic [7:0]  cur_tag;

    logic        nxt_commit;
    logic        nxt_wen;
    logic [7:0]  nxt_waddr;
    logic [23:0] nxt_wdata;

    // Exactly two queued entries are younger than the one whose output is visible now.
    always @(negedge clk) begin
        if (mon_en && sb.size() >= 3) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if ({o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE} !== {e.data, e.hs, e.vs, e.de}) begin
                n_err++;
                $display("FAIL pixel(test %0d) got data=%06h hs=%b vs=%b de=%b expected data=%06h hs=%b vs=%b de=%b",
                         e.tag, o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
                         e.data, e.hs, e.vs, e.de);
            end
        end
    end

    task automatic drive(input logic [7:0] g, input logic de, input logic hs, input logic vs,
                         input logic [23:0] exp_data);
        exp_t e;
        @(posedge clk);
        #1;
        i_vid_data  = g;
        i_vid_VDE   = de;
        i_vid_hsync = hs;
        i_vid_vsync = vs;
        pal_commit  = nxt_commit;
        pal_wr_en   = nxt_wen;
        pal_wr_addr = nxt_waddr;
        pal_wr_data = nxt_wdata;
        nxt_commit  = 1'b0;
        nxt_wen     = 1'b0;
        nxt_waddr   = '0;
        nxt_wdata   = '0;
        e.data = exp_data;
        e.hs   = hs;
        e.vs   = vs;
        e.de   = de;
        e.tag  = cur_tag;
        sb.push_back(e);
    endtask

    task automatic pix(input logic [7:0] g, input logic [23:0] exp_data);
        drive(g, 1'b1, 1'b0, 1'b0, exp_data);
    endtask

    task automatic blank(input logic [7:0] g);
        drive(g, 1'b0, 1'b0, 1'b0, 24'h000000);
    endtask

    task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
        nxt_wen   = 1'b1;
        nxt_waddr = a;
        nxt_wdata = d;
        blank(8'h00);
    endtask

    // Blanking interval; commit/write arguments land on the vsync-rise cycle.
    task automatic vsync_frame(input logic commit, input logic wen, input logic [7:0] wa,
                               input logic [23:0] wd);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 24'h0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 24'h0);
        nxt_commit = commit;
        nxt_wen    = wen;
        nxt_waddr  = wa;
        nxt_wdata  = wd;
        drive(8'hFF, 1'b0, 1'b0, 1'b1, 24'h0);
        drive(8'hFF, 1'b0, 1'b1, 1'b1, 24'h0);
        drive(8'h00, 1'b0, 1'b0, 1'b1, 24'h0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 24'h0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic chk_pend(input logic exp_p, input string name);
        n_vec++;
        if (pal_pending !== exp_p) begin
            n_err++;
            $display("FAIL %s pal_pending got %b expected %b", name, pal_pending, exp_p);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        n_vec++;
        if ({o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE, pal_pending} !== 28'h0) begin
            n_err++;
            $display("FAIL %s got data=%06h hs=%b vs=%b de=%b pend=%b expected all zero",
                     name, o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE, pal_pending);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; mon_en = 1'b0; cur_tag = 8'd0;
        nxt_commit = 1'b0; nxt_wen = 1'b0; nxt_waddr = '0; nxt_wdata = '0;
        rst = 1'b1;
        i_vid_data = '0; i_vid_hsync = 1'b0; i_vid_vsync = 1'b0; i_vid_VDE = 1'b0;
        btn = 4'b0000;
        pal_wr_en = 1'b0; pal_wr_addr = '0; pal_wr_data = '0; pal_commit = 1'b0;
        #1;
        chk_reset_outputs("reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Test 1: replicated grey and 2-cycle sync alignment
        cur_tag = 8'd1;
        pix(8'h40, 24'h404040);
        drive(8'h40, 1'b1, 1'b1, 1'b0, 24'h404040);
        drive(8'h41, 1'b1, 1'b0, 1'b1, 24'h414141);
        blank(8'h40);
        pix(8'hA5, 24'hA5A5A5);

        // Palette setup: fill bank 1, swap in, then fill bank 0 and swap back
        cur_tag = 8'd10;
        pal_write(8'h10, 24'hAAAAAA);
        pal_write(8'h20, 24'h123456);
        nxt_commit = 1'b1;
        blank(8'h00);
        blank(8'h00);
        chk_pend(1'b1, "setup_commit1");
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        chk_pend(1'b0, "setup_swap1");
        pal_write(8'h10, 24'h0A0B0C);
        pal_write(8'h20, 24'h0D0E0F);
        nxt_commit = 1'b1;
        blank(8'h00);
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);

        // Test 2: mode request mid-frame waits for vsync
        cur_tag = 8'd2;
        pix(8'h10, 24'h101010);
        btn = 4'b1101;
        pix(8'h10, 24'h101010);
        pix(8'h20, 24'h202020);
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        pix(8'h10, 24'h0A0B0C);
        pix(8'h20, 24'h0D0E0F);

        // Test 3: write inactive bank, commit, swap at frame boundary
        cur_tag = 8'd3;
        pal_write(8'h10, 24'h112233);
        nxt_commit = 1'b1;
        blank(8'h00);
        blank(8'h00);
        chk_pend(1'b1, "t3_pending");
        pix(8'h10, 24'h0A0B0C);
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        chk_pend(1'b0, "t3_swapped");
        pix(8'h10, 24'h112233);
        pix(8'h20, 24'h123456);

        // Test 4: commit on the fb cycle waits one frame; repeated commit swaps once
        cur_tag = 8'd4;
        pal_write(8'h10, 24'h445566);
        vsync_frame(1'b1, 1'b0, 8'h00, 24'h0);
        chk_pend(1'b1, "t4_commit_at_fb");
        pix(8'h10, 24'h112233);
        nxt_commit = 1'b1;
        pix(8'h10, 24'h112233);
        chk_pend(1'b1, "t4_second_commit");
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        chk_pend(1'b0, "t4_swapped");
        pix(8'h10, 24'h445566);
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        pix(8'h10, 24'h445566);

        // Write coinciding with the swap lands in the newly active bank
        cur_tag = 8'd40;
        nxt_commit = 1'b1;
        blank(8'h00);
        vsync_frame(1'b0, 1'b1, 8'h30, 24'h778899);
        pix(8'h30, 24'h778899);

        // Test 5: threshold, invert, and blanking in every mode
        cur_tag = 8'd5;
        btn = 4'b0011;
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        pix(8'h7F, 24'h000000);
        pix(8'h80, 24'hFFFFFF);
        blank(8'hFF);
        btn = 4'b0010;
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        pix(8'h0F, 24'hF0F0F0);
        pix(8'h00, 24'hFFFFFF);
        blank(8'hFF);
        btn = 4'b0000;
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        pix(8'hFF, 24'hFFFFFF);
        blank(8'hFF);
        btn = 4'b0001;
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        blank(8'h10);
        pix(8'h10, 24'h112233);

        // Test 6: reset mid-frame while pending in palette mode
        cur_tag = 8'd6;
        nxt_commit = 1'b1;
        pix(8'h10, 24'h112233);
        pix(8'h10, 24'h112233);
        chk_pend(1'b1, "t6_pending");
        pix(8'h30, 24'h778899);
        #2;
        mon_en = 1'b0;
        sb.delete();
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_reset_immediate");
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        pix(8'h10, 24'h101010);
        pix(8'h33, 24'h333333);
        vsync_frame(1'b0, 1'b0, 8'h00, 24'h0);
        chk_pend(1'b0, "t6_no_swap");
        pix(8'h10, 24'h445566);
        pix(8'h20, 24'h0D0E0F);

        repeat (3) blank(8'h00);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grey_colourise.md
Name: grey_colourise

Overview:
- Output-side counterpart to the greyscale stage: expands an 8-bit grey pixel stream back to 24-bit RGB for the display path.
- Four modes: replicated grey, inverted grey, fixed threshold, and pseudo-colour through a programmable 256-entry palette.
- The palette is double-buffered. Software fills the inactive bank, and the bank swap, like every mode change, takes effect only at a frame boundary (vsync rising edge).
- Sits between the greyscale stage and the HDMI/VGA encoder.

Parameters:
- DATA_WIDTH, 24, output pixel width (8 bits each for R, G, B, packed {R,G,B}).
- GREY_WIDTH, 8, input pixel width; palette depth is 2**GREY_WIDTH.
- THRESHOLD, 128, threshold for mode 11.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- i_vid_data  in  GREY_WIDTH  grey pixel
- i_vid_hsync  in  1  horizontal sync
- i_vid_vsync  in  1  vertical sync
- i_vid_VDE  in  1  video data enable
- o_vid_data  out  DATA_WIDTH  RGB pixel {R,G,B}
- o_vid_hsync  out  1  hsync delayed to match data
- o_vid_vsync  out  1  vsync delayed to match data
- o_vid_VDE  out  1  VDE delayed to match data
- btn  in  4  btn[1:0] mode request; btn[3:2] unused
- pal_wr_en  in  1  palette write strobe
- pal_wr_addr  in  GREY_WIDTH  palette entry index
- pal_wr_data  in  DATA_WIDTH  palette entry {R,G,B}
- pal_commit  in  1  single-cycle request to swap banks at next frame boundary
- pal_pending  out  1  commit accepted, swap not yet done

Behaviour:
- Reset (async assert, sync release): all outputs 0; pipeline regs 0; vsync-edge reg 0; bank_sel=0; mode=00; pal_pending=0. Palette contents are not reset (undefined until written).
- Frame boundary (fb): i_vid_vsync=1 in the current cycle and 0 in the previous cycle, using a registered previous vsync.
- Mode register: loads btn[1:0] only on fb, so a mode never changes mid-frame.
- Mode output mapping, g = grey pixel:
  - 00: {g,g,g}
  - 01: palette[active][g]
  - 10: {~g,~g,~g}
  - 11: g>=THRESHOLD ? 24'hFFFFFF : 24'h000000
- Pipeline latency is exactly 2 cycles for data, hsync, vsync and VDE. Sync/VDE pass through unchanged, delayed by 2.
  - Stage 1 registers g, syncs and VDE.
  - Stage 2 performs lookup/mapping and registers the outputs.
- Blanking: o_vid_data=0 whenever the delayed VDE is 0, in every mode.
- The mode and bank used for a pixel are the values held when that pixel enters stage 2. A switch at fb therefore affects the first pixel of the new frame; pixels in flight during the vsync period are blanked anyway.
- Palette: two banks of 2**GREY_WIDTH x DATA_WIDTH.
  - Active bank = bank_sel; writes always go to bank ~bank_sel, evaluated with the pre-edge bank_sel.
  - A write in the same cycle as a swap lands in the bank that becomes active.
- Commit state machine, states IDLE / PENDING:
  - IDLE: pal_commit=1 → PENDING (pal_pending=1 from the next cycle).
  - PENDING: fb → toggle bank_sel, return to IDLE (pal_pending=0 next cycle).
  - PENDING: further pal_commit pulses are ignored.
  - A commit in the same cycle as fb does not swap on that fb; it waits for the next one.
- The new bank does not copy the old one; software must rewrite every needed entry after each swap.
- Reset mid-frame: outputs clear immediately; the next frame runs in mode 00, bank 0, until a new fb.
- Widths: all arithmetic is unsigned; inversion is a bitwise complement within GREY_WIDTH.

Test Plan:
1. Reset, then VDE=1 with g=0x40, mode 00 → o_vid_data=0x404040 exactly 2 cycles later; hsync/vsync/VDE also delayed by exactly 2 cycles.
2. btn=01 mid-frame; data stays replicated grey until next vsync rise; then g=0x10 → palette[0][0x10].
3. Write palette[1][0x10]=0x112233 and pulse pal_commit → pal_pending=1; output still from bank 0 until fb; after fb, g=0x10 → 0x112233 and pal_pending=0.
4. pal_commit in the same cycle as fb → no swap on that fb; swap occurs at the following fb. A second commit while pending produces exactly one swap.
5. Mode 11: g=0x7F → 0x000000, g=0x80 → 0xFFFFFF. Mode 10: g=0x0F → 0xF0F0F0. VDE=0 with g=0xFF → 0x000000 in all modes.
6. Assert rst mid-frame while PENDING in mode 01 → all outputs 0 immediately, pal_pending=0, bank_sel=0. Next frame is mode 00 until a new btn value is sampled at fb.
